sp_sync_ram_hs: RTL and testbench



---
 rtl/sp_ram_pkg.sv | 17 +
 rtl/sp_ram_core.sv | 55 +++++
 rtl/sp_sync_ram_hs.sv | 162 ++++++++++++++++
 tb/tb_sp_sync_ram_hs.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sp_ram_pkg.sv
// sp_ram_pkg -- shared types and helpers for the sp_sync_ram_hs block.
//   state_e   : top-level controller state (init sweep / normal operation)
//   byte_mask : expands one byte-enable bit into an 8-bit write mask
package sp_ram_pkg;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  // One byte-enable bit covers eight data bits; the top level applies this
  // per byte lane to build the full DATA_WIDTH bit mask.
  function automatic logic [7:0] byte_mask(input logic be_bit);
    return {8{be_bit}};
  endfunction

endpackage

// File: rtl/sp_ram_core.sv
// sp_ram_core -- bare storage array with one bit-masked write port and one
// registered read port.
//   clk, rst    : clock, synchronous active-high reset (read register only)
//   wr_en_i     : write strobe
//   wr_addr_i   : write word address (caller guarantees < DEPTH)
//   wr_data_i   : write data
//   wr_mask_i   : per-bit write mask, 1 = update that bit
//   rd_en_i     : load the read register this edge
//   rd_zero_i   : with rd_en_i, load zero instead of array contents
//   rd_addr_i   : read word address
//   rd_data_o   : registered read data, holds between reads
module sp_ram_core #(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 32,
  parameter int AW         = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [DATA_WIDTH-1:0] wr_mask_i,
  input  logic                  rd_en_i,
  input  logic                  rd_zero_i,
  input  logic [AW-1:0]         rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Array contents are never reset; the top level sweeps them after reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        if (wr_mask_i[i]) begin
          mem_q[wr_addr_i][i] <= wr_data_i[i];
        end
      end
    end
  end

  // Zero-load lets out-of-range reads return 0 without a mux after the
  // register, so the output still holds its last value between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= rd_zero_i ? '0 : mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sp_sync_ram_hs.sv
// sp_sync_ram_hs -- single-port synchronous RAM with valid/ready requests,
// byte enables, bounds checking, self-initialisation and optional output reg.
//   clk, rst   : clock, synchronous active-high reset
//   req_valid  : request present        req_ready : request accepted this cycle
//   req_we     : 1 = write, 0 = read    req_addr  : word address
//   req_wdata  : write data             req_be    : byte enables
//   rsp_valid  : one-cycle read response pulse
//   rsp_rdata  : read data (holds when rsp_valid=0)
//   rsp_err    : response was for an address >= DEPTH
//   init_done  : init sweep finished
module sp_sync_ram_hs
  import sp_ram_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    DATA_WIDTH = 24,
  parameter int                    DEPTH      = 32,
  parameter int                    OUT_REG    = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    init_done
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int AW_C = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW   = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0]         LAST_PTR  = PW'(DEPTH - 1);
  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0]   DEPTH_CMP = (ADDR_WIDTH + 1)'(DEPTH);

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;

  logic                  in_range;
  logic                  accept;
  logic                  rd_fire;
  logic [DATA_WIDTH-1:0] be_mask;

  logic                  wr_en;
  logic [AW_C-1:0]       wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] wr_mask;
  logic [DATA_WIDTH-1:0] core_rdata;

  logic s1_valid_q;
  logic s1_err_q;

  for (genvar gi = 0; gi < NB; gi++) begin : g_be_mask
    assign be_mask[8*gi +: 8] = byte_mask(req_be[gi]);
  end

  assign req_ready = (state_q == S_RUN);
  assign init_done = (state_q == S_RUN);
  assign in_range  = ({1'b0, req_addr} < DEPTH_CMP);
  // A request coinciding with reset is ignored so nothing lands in memory.
  assign accept    = req_valid & req_ready & ~rst;
  assign rd_fire   = accept & ~req_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state plus the write-port mux: the sweep owns the port during
  // S_INIT, requests own it during S_RUN.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wr_en   = 1'b0;
    wr_addr = req_addr[AW_C-1:0];
    wr_data = req_wdata;
    wr_mask = be_mask;
    unique case (state_q)
      S_INIT: begin
        wr_en   = ~rst;
        wr_addr = ptr_q[AW_C-1:0];
        wr_data = INIT_VAL;
        wr_mask = '1;
        ptr_d   = ptr_q + 1'b1;
        if (ptr_q == LAST_PTR) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        wr_en = accept & req_we & in_range;
      end
      default: state_d = S_INIT;
    endcase
  end

  sp_ram_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW_C)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .wr_mask_i (wr_mask),
    .rd_en_i   (rd_fire),
    .rd_zero_i (~in_range),
    .rd_addr_i (req_addr[AW_C-1:0]),
    .rd_data_o (core_rdata)
  );

  // First pipeline stage tracks the read register in the core.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= rd_fire;
      s1_err_q   <= rd_fire & ~in_range;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        rsp_valid_q <= 1'b0;
        rsp_err_q   <= 1'b0;
        rsp_rdata_q <= '0;
      end else begin
        rsp_valid_q <= s1_valid_q;
        rsp_err_q   <= s1_err_q;
        if (s1_valid_q) begin
          rsp_rdata_q <= core_rdata;
        end
      end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
  end else begin : g_no_out_reg
    assign rsp_valid = s1_valid_q;
    assign rsp_err   = s1_err_q;
    assign rsp_rdata = core_rdata;
  end

endmodule

// File: tb/tb_sp_sync_ram_hs.sv
// tb_sp_sync_ram_hs -- directed scenarios plus random traffic, checked every
// cycle against a behavioural model of the RAM, with literal spot checks.
module tb_sp_sync_ram_hs;

  localparam int                ADDR_WIDTH = 5;
  localparam int                DATA_WIDTH = 24;
  localparam int                DEPTH      = 24;
  localparam int                OUT_REG    = 1;
  localparam logic [23:0]       INIT_VAL   = 24'h5A5A5A;
  localparam int                LAT        = (OUT_REG != 0) ? 2 : 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [4:0]  req_addr = '0;
  logic [23:0] req_wdata = '0;
  logic [2:0]  req_be = '0;
  logic        rsp_valid;
  logic [23:0] rsp_rdata;
  logic        rsp_err;
  logic        init_done;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  sp_sync_ram_hs #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .OUT_REG    (OUT_REG),
    .INIT_VAL   (INIT_VAL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        v;
    logic        e;
    logic [23:0] d;
  } rsp_t;

  logic [23:0] m_mem [DEPTH];
  int          m_sweep = 0;       // words initialised since reset released
  rsp_t        m_pipe [LAT];
  logic        m_ready = 1'b0;
  logic        m_valid = 1'b0;
  logic        m_err   = 1'b0;
  logic [23:0] m_rdata = '0;

  always @(posedge clk) begin
    rsp_t nw;
    nw = '0;
    if (rst) begin
      m_sweep = 0;
      for (int i = 0; i < LAT; i++) m_pipe[i] = '0;
      m_ready = 1'b0;
      m_valid = 1'b0;
      m_err   = 1'b0;
      m_rdata = '0;
    end else begin
      if (m_ready && req_valid) begin
        if (int'(req_addr) < DEPTH) begin
          if (req_we) begin
            for (int b = 0; b < 3; b++)
              if (req_be[b]) m_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
          end else begin
            nw = '{v: 1'b1, e: 1'b0, d: m_mem[req_addr]};
          end
        end else if (!req_we) begin
          nw = '{v: 1'b1, e: 1'b1, d: 24'h0};
        end
      end
      if (m_sweep < DEPTH) begin
        m_mem[m_sweep] = INIT_VAL;
        m_sweep++;
      end
      for (int i = LAT - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = nw;
      m_valid = m_pipe[LAT-1].v;
      m_err   = m_pipe[LAT-1].e;
      if (m_pipe[LAT-1].v) m_rdata = m_pipe[LAT-1].d;
      m_ready = (m_sweep == DEPTH);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready", 32'(req_ready), 32'(m_ready));
      check("init_done", 32'(init_done), 32'(m_ready));
      check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      check("rsp_err",   32'(rsp_err),   32'(m_err));
      check("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v, input logic we, input logic [4:0] a,
                       input logic [23:0] d, input logic [2:0] be);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
  endtask

  task automatic cycle(input logic v, input logic we, input logic [4:0] a,
                       input logic [23:0] d, input logic [2:0] be);
    @(negedge clk);
    drive(v, we, a, d, be);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Issues one read and waits (bounded) for its response.
  task automatic do_read(input logic [4:0] a, output logic [23:0] d,
                         output logic e, output int lat);
    cycle(1'b1, 1'b0, a, 24'h0, 3'b000);
    lat = 0;
    d   = 'x;
    e   = 'x;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) drive(1'b0, 1'b0, 5'd0, 24'h0, 3'b000);
      if (rsp_valid) begin
        lat = k;
        d   = rsp_rdata;
        e   = rsp_err;
        break;
      end
    end
  endtask

  initial begin
    @(posedge clk);
    chk_en = 1'b1;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int          n;
    int          lat;
    logic [23:0] d;
    logic        e;
    logic        v_s [5];
    logic [23:0] d_s [5];
    int          pulses;
    logic [4:0]  ra [3];

    // 1. reset and init sweep
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", 32'(rsp_rdata), 32'd0);
    rst = 1'b0;
    wait_ready(n);
    check("init_cycles", 32'(n), 32'(DEPTH));
    ra[0] = 5'd0; ra[1] = 5'd17; ra[2] = 5'd23;
    for (int i = 0; i < 3; i++) begin
      do_read(ra[i], d, e, lat);
      check("init_read_data", 32'(d), 32'h5A5A5A);
      check("init_read_err", 32'(e), 32'd0);
      check("read_latency", 32'(lat), 32'(LAT));
    end

    // 2. byte enables
    cycle(1'b1, 1'b1, 5'd0, 24'hABCDEF, 3'b111);
    cycle(1'b1, 1'b1, 5'd0, 24'h112233, 3'b010);
    cycle(1'b0, 1'b0, 5'd0, 24'h0, 3'b000);
    do_read(5'd0, d, e, lat);
    check("be_merge", 32'(d), 32'hAB22EF);
    check("be_err", 32'(e), 32'd0);

    // 3. back-to-back reads
    cycle(1'b1, 1'b1, 5'd1, 24'h000001, 3'b111);
    cycle(1'b1, 1'b1, 5'd2, 24'h000002, 3'b111);
    cycle(1'b1, 1'b1, 5'd3, 24'h000003, 3'b111);
    cycle(1'b0, 1'b0, 5'd0, 24'h0, 3'b000);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      if (c < 3) drive(1'b1, 1'b0, 5'(c + 1), 24'h0, 3'b000);
      else       drive(1'b0, 1'b0, 5'd0, 24'h0, 3'b000);
      @(posedge clk);
      @(negedge clk);
      v_s[c] = rsp_valid;
      d_s[c] = rsp_rdata;
    end
    drive(1'b0, 1'b0, 5'd0, 24'h0, 3'b000);
    check("b2b_valid0", 32'(v_s[0]), 32'd0);
    for (int c = 1; c <= 3; c++) begin
      check("b2b_valid", 32'(v_s[c]), 32'd1);
      check("b2b_data", 32'(d_s[c]), 32'(c));
    end
    check("b2b_valid4", 32'(v_s[4]), 32'd0);

    // 4. out of range
    do_read(5'd25, d, e, lat);
    check("oob_err", 32'(e), 32'd1);
    check("oob_data", 32'(d), 32'd0);
    cycle(1'b1, 1'b1, 5'd25, 24'hFFFFFF, 3'b111);
    do_read(5'd1, d, e, lat);
    check("oob_write_dropped", 32'(d), 32'h000001);

    // 5. write then read next cycle
    cycle(1'b1, 1'b1, 5'd7, 24'h123456, 3'b111);
    do_read(5'd7, d, e, lat);
    check("wr_then_rd", 32'(d), 32'h123456);

    // 6. reset with a read in flight
    cycle(1'b1, 1'b0, 5'd2, 24'h0, 3'b000);
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 24'h0, 3'b000);
    rst = 1'b1;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    check("flight_discarded", 32'(pulses), 32'd0);
    check("flight_init_done", 32'(init_done), 32'd0);
    rst = 1'b0;
    wait_ready(n);
    check("reinit_cycles", 32'(n), 32'(DEPTH));
    do_read(5'd2, d, e, lat);
    check("reinit_data", 32'(d), 32'h5A5A5A);

    // 7. random traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 599) == 0);
      drive(($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 31)), 24'($urandom), 3'($urandom_range(0, 7)));
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 24'h0, 3'b000);
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
